// File: rtl/matdet_seq.sv
// Sequential fixed-point determinant engine for 2x2 or 3x3 matrices.
// One shared multiplier issues one product per clock. Overflow is sticky for the whole computation.
module matdet_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]  a,
    output logic                                           busy,
    output logic                                           done,
    output logic [DATA_WIDTH-1:0]                          det,
    output logic                                           overflow
);

    localparam int N      = MATRIX_SIZE;
    localparam int NE     = N * N;
    localparam int K      = (N == 2) ? 2 : 9;
    localparam int STEP_W = 4;
    localparam int MSB    = DATA_WIDTH - 1;

    generate
        if (N != 2 && N != 3) begin : g_bad_size
            $error("matdet_seq: MATRIX_SIZE must be 2 or 3");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {OP_MINOR_LOAD, OP_MINOR_SUB, OP_ACC_LOAD, OP_ACC_ADD, OP_ACC_SUB} op_t;

    state_t                          state_reg, state_next;
    logic [DATA_WIDTH*NE-1:0]        a_reg;
    logic [STEP_W-1:0]               step_reg;
    logic signed [DATA_WIDTH-1:0]    acc_reg, minor_reg;
    logic signed [DATA_WIDTH-1:0]    acc_next, minor_next;
    logic                            ovf_acc_reg;
    logic                            busy_reg, done_reg, overflow_reg;
    logic [DATA_WIDTH-1:0]           det_reg;

    logic signed [DATA_WIDTH-1:0]    elem [NE];
    logic signed [DATA_WIDTH-1:0]    mul_x, mul_y;
    op_t                             op;

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_elem
            assign elem[gi] = a_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Per-step operand schedule; the size-3 case expands along row 0, three steps per column.
    generate
        if (N == 2) begin : g_sched2
            always_comb begin
                mul_x = elem[0];
                mul_y = elem[3];
                op    = OP_ACC_LOAD;
                if (step_reg != '0) begin
                    mul_x = elem[1];
                    mul_y = elem[2];
                    op    = OP_ACC_SUB;
                end
            end
        end else begin : g_sched3
            always_comb begin
                mul_x = elem[4];
                mul_y = elem[8];
                op    = OP_MINOR_LOAD;
                case (step_reg)
                    4'd1: begin mul_x = elem[5]; mul_y = elem[7];  op = OP_MINOR_SUB;  end
                    4'd2: begin mul_x = elem[0]; mul_y = minor_reg; op = OP_ACC_ADD;   end
                    4'd3: begin mul_x = elem[3]; mul_y = elem[8];  op = OP_MINOR_LOAD; end
                    4'd4: begin mul_x = elem[5]; mul_y = elem[6];  op = OP_MINOR_SUB;  end
                    4'd5: begin mul_x = elem[1]; mul_y = minor_reg; op = OP_ACC_SUB;   end
                    4'd6: begin mul_x = elem[3]; mul_y = elem[7];  op = OP_MINOR_LOAD; end
                    4'd7: begin mul_x = elem[4]; mul_y = elem[6];  op = OP_MINOR_SUB;  end
                    4'd8: begin mul_x = elem[2]; mul_y = minor_reg; op = OP_ACC_ADD;   end
                    default: ;
                endcase
            end
        end
    endgenerate

    logic signed [2*DATA_WIDTH-1:0] prod_full, prod_shift;
    logic signed [DATA_WIDTH-1:0]   prod, base, res;
    logic                           prod_ovf, is_sub, is_minor, as_ovf, step_ovf;

    assign prod_full  = mul_x * mul_y;
    assign prod_shift = prod_full >>> BIN_POS;
    assign prod       = prod_shift[DATA_WIDTH-1:0];
    // The shifted product fits only if every bit from the result sign upward is identical.
    assign prod_ovf   = !((&prod_shift[2*DATA_WIDTH-1:MSB]) || !(|prod_shift[2*DATA_WIDTH-1:MSB]));

    assign is_minor = (op == OP_MINOR_LOAD) || (op == OP_MINOR_SUB);
    assign is_sub   = (op == OP_MINOR_SUB) || (op == OP_ACC_SUB);
    assign base     = is_minor ? minor_reg : acc_reg;
    assign res      = is_sub ? base - prod : base + prod;
    assign as_ovf   = is_sub ? ((base[MSB] != prod[MSB]) && (res[MSB] != base[MSB]))
                             : ((base[MSB] == prod[MSB]) && (res[MSB] != base[MSB]));

    always_comb begin
        acc_next   = acc_reg;
        minor_next = minor_reg;
        step_ovf   = prod_ovf;
        case (op)
            OP_MINOR_LOAD: minor_next = prod;
            OP_MINOR_SUB:  begin minor_next = res; step_ovf = prod_ovf | as_ovf; end
            OP_ACC_LOAD:   acc_next = prod;
            default:       begin acc_next = res; step_ovf = prod_ovf | as_ovf; end
        endcase
    end

    wire last_step = (step_reg == STEP_W'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg        <= '0;
            step_reg     <= '0;
            acc_reg      <= '0;
            minor_reg    <= '0;
            ovf_acc_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            det_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    a_reg       <= a;
                    acc_reg     <= '0;
                    minor_reg   <= '0;
                    ovf_acc_reg <= 1'b0;
                    busy_reg    <= 1'b1;
                    step_reg    <= '0;
                end
            end else begin
                acc_reg     <= acc_next;
                minor_reg   <= minor_next;
                ovf_acc_reg <= ovf_acc_reg | step_ovf;
                step_reg    <= step_reg + 1'b1;
                if (last_step) begin
                    det_reg      <= acc_next;
                    overflow_reg <= ovf_acc_reg | step_ovf;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    step_reg     <= '0;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign det      = det_reg;
    assign overflow = overflow_reg;

endmodule
